alarm_match_bank: RTL and testbench

Multi-channel alarm comparator for the clock/timer datapath. Compares the running H/M/S time against NUM_CH programmed alarm times, raises a latched ring flag per channel on a match edge, and holds it until acknowledged or until a ring timeout expires. Sits between the time-count registers and the buzzer/LED driver, replacing the single-channel finish comparator.

---
 rtl/alarm_match_bank_if.sv | 44 ++++
 rtl/alarm_match_bank.sv | 175 +++++++++++++++++
 tb/tb_alarm_match_bank.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_match_bank_if.sv
// Bus bundle between the time-count registers, the alarm bank and the
// buzzer/LED driver. The snooze request exists only when ALARM_SNOOZE_EN is
// defined.
interface alarm_match_bank_if #(
    parameter int NUM_CH  = 4,
    parameter int FIELD_W = 8
);
    localparam int AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                      sec_tick;
    logic [FIELD_W-1:0]        count_h;
    logic [FIELD_W-1:0]        count_m;
    logic [FIELD_W-1:0]        count_s;
    logic [NUM_CH*FIELD_W-1:0] prog_h;
    logic [NUM_CH*FIELD_W-1:0] prog_m;
    logic [NUM_CH*FIELD_W-1:0] prog_s;
    logic [NUM_CH-1:0]         ch_en;
    logic                      ack;
`ifdef ALARM_SNOOZE_EN
    logic                      snooze;
`endif
    logic [NUM_CH-1:0]         ring;
    logic                      fin;
    logic [AW-1:0]             active_ch;
    logic                      timeout;

    modport master (
`ifdef ALARM_SNOOZE_EN
        output snooze,
`endif
        output sec_tick, count_h, count_m, count_s,
        output prog_h, prog_m, prog_s, ch_en, ack,
        input  ring, fin, active_ch, timeout
    );

    modport slave (
`ifdef ALARM_SNOOZE_EN
        input  snooze,
`endif
        input  sec_tick, count_h, count_m, count_s,
        input  prog_h, prog_m, prog_s, ch_en, ack,
        output ring, fin, active_ch, timeout
    );
endinterface

// File: rtl/alarm_match_bank.sv
// alarm_match_bank: NUM_CH alarm comparators against the running H/M/S time.
// Each channel rings once on the rising edge of its match, until ack or until
// RING_SECS sec_ticks have elapsed (one-cycle timeout pulse).
// Optional feature macro: ALARM_SNOOZE_EN adds the snooze input and a SNOOZE
// state lasting SNOOZE_SECS sec_ticks before the channel rings again.
module alarm_match_bank #(
    parameter int NUM_CH      = 4,
    parameter int FIELD_W     = 8,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300
) (
    input  logic              clock,
    input  logic              reset,
    alarm_match_bank_if.slave bus
);
    localparam int AW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int MAX_SECS = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
    localparam int CW       = $clog2(MAX_SECS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RING  = 2'd2
`ifdef ALARM_SNOOZE_EN
        , ST_SNOOZE = 2'd3
`endif
    } state_e;

    state_e            state_q [NUM_CH];
    state_e            state_d [NUM_CH];
    logic [CW-1:0]     cnt_q   [NUM_CH];
    logic [CW-1:0]     cnt_d   [NUM_CH];
    logic [NUM_CH-1:0] match_s;
    logic [NUM_CH-1:0] match_q;
    logic [NUM_CH-1:0] edge_s;
    logic [NUM_CH-1:0] ring_q;
    logic [NUM_CH-1:0] ring_d;
    logic              timeout_q;
    logic              timeout_d;
    logic [AW-1:0]     active_s;
    logic              snooze_s;

`ifdef ALARM_SNOOZE_EN
    assign snooze_s = bus.snooze;
`else
    assign snooze_s = 1'b0;
`endif

    // Per-channel time comparison; an all-zero programmed time never matches.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((bus.prog_h[i*FIELD_W +: FIELD_W] == bus.count_h) &&
                (bus.prog_m[i*FIELD_W +: FIELD_W] == bus.count_m) &&
                (bus.prog_s[i*FIELD_W +: FIELD_W] == bus.count_s) &&
                ({bus.prog_h[i*FIELD_W +: FIELD_W],
                  bus.prog_m[i*FIELD_W +: FIELD_W],
                  bus.prog_s[i*FIELD_W +: FIELD_W]} != {(3*FIELD_W){1'b0}})) begin
                match_s[i] = 1'b1;
            end else begin
                match_s[i] = 1'b0;
            end
        end
    end

    assign edge_s = match_s & ~match_q;

    // Channel FSMs and ring/snooze counters: next state and timeout pulse.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ring_d    = '0;
        timeout_d = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!bus.ch_en[i]) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        state_d[i] = ST_ARMED;
                        cnt_d[i]   = '0;
                    end
                    ST_ARMED: begin
                        if (edge_s[i]) begin
                            state_d[i] = ST_RING;
                            cnt_d[i]   = '0;
                        end else begin
                            state_d[i] = ST_ARMED;
                        end
                    end
                    ST_RING: begin
                        if (bus.ack) begin
                            state_d[i] = ST_ARMED;
                            cnt_d[i]   = '0;
`ifdef ALARM_SNOOZE_EN
                        end else if (snooze_s) begin
                            state_d[i] = ST_SNOOZE;
                            cnt_d[i]   = '0;
`endif
                        end else if (bus.sec_tick) begin
                            if (cnt_q[i] == CW'(RING_SECS - 1)) begin
                                state_d[i] = ST_ARMED;
                                cnt_d[i]   = '0;
                                timeout_d  = 1'b1;
                            end else begin
                                cnt_d[i] = cnt_q[i] + {{(CW-1){1'b0}}, 1'b1};
                            end
                        end else begin
                            state_d[i] = ST_RING;
                        end
                    end
`ifdef ALARM_SNOOZE_EN
                    ST_SNOOZE: begin
                        if (bus.ack) begin
                            state_d[i] = ST_ARMED;
                            cnt_d[i]   = '0;
                        end else if (bus.sec_tick) begin
                            if (cnt_q[i] == CW'(SNOOZE_SECS - 1)) begin
                                state_d[i] = ST_RING;
                                cnt_d[i]   = '0;
                            end else begin
                                cnt_d[i] = cnt_q[i] + {{(CW-1){1'b0}}, 1'b1};
                            end
                        end else begin
                            state_d[i] = ST_SNOOZE;
                        end
                    end
`endif
                    default: begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
            ring_d[i] = (state_d[i] == ST_RING);
        end
    end

    // State, counter, match history and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            match_q   <= '0;
            ring_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            match_q   <= match_s;
            ring_q    <= ring_d;
            timeout_q <= timeout_d;
        end
    end

    // Lowest-index ringing channel; zero when nothing rings.
    always_comb begin
        active_s = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ring_q[i]) begin
                active_s = AW'(i);
            end else begin
                active_s = active_s;
            end
        end
    end

    assign bus.ring      = ring_q;
    assign bus.fin       = |ring_q;
    assign bus.active_ch = active_s;
    assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_alarm_match_bank.sv
// Self-checking bench for alarm_match_bank: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// behavioural model of the alarm rules.
module tb_alarm_match_bank;
    localparam int NUM_CH      = 4;
    localparam int FIELD_W     = 8;
    localparam int RING_SECS   = 3;
    localparam int SNOOZE_SECS = 2;
    localparam int AW          = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   cmp_on  = 1'b0;

    alarm_match_bank_if #(.NUM_CH(NUM_CH), .FIELD_W(FIELD_W)) bus ();

    alarm_match_bank #(
        .NUM_CH(NUM_CH), .FIELD_W(FIELD_W),
        .RING_SECS(RING_SECS), .SNOOZE_SECS(SNOOZE_SECS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    // mode: 0 disabled, 1 waiting for alarm, 2 ringing, 3 snoozing
    int              mode    [NUM_CH];
    int              elapsed [NUM_CH];
    bit              was_hit [NUM_CH];
    bit [NUM_CH-1:0] exp_ring = '0;
    bit              exp_to   = 1'b0;

    function automatic bit time_hit(int ch);
        logic [FIELD_W-1:0] h, m, s;
        h = bus.prog_h[ch*FIELD_W +: FIELD_W];
        m = bus.prog_m[ch*FIELD_W +: FIELD_W];
        s = bus.prog_s[ch*FIELD_W +: FIELD_W];
        if (h == 0 && m == 0 && s == 0) return 1'b0;
        return (h == bus.count_h) && (m == bus.count_m) && (s == bus.count_s);
    endfunction

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            mode[c] = 0; elapsed[c] = 0; was_hit[c] = 1'b0;
        end
    end

    // Model advances once per rising edge using the inputs held since the falling edge.
    always @(posedge clock) begin
        int              md [NUM_CH];
        int              el [NUM_CH];
        bit              hh [NUM_CH];
        bit [NUM_CH-1:0] rr;
        bit              to;
        bit              hit;
        bit              snz;
        to = 1'b0;
        rr = '0;
`ifdef ALARM_SNOOZE_EN
        snz = bus.snooze;
`else
        snz = 1'b0;
`endif
        for (int c = 0; c < NUM_CH; c++) begin
            md[c] = mode[c]; el[c] = elapsed[c];
            hit = time_hit(c);
            if (reset) begin
                md[c] = 0; el[c] = 0; hh[c] = 1'b0;
            end else begin
                if (!bus.ch_en[c]) begin
                    md[c] = 0; el[c] = 0;
                end else if (md[c] == 0) begin
                    md[c] = 1;
                end else if (md[c] == 1) begin
                    if (hit && !was_hit[c]) begin md[c] = 2; el[c] = 0; end
                end else if (md[c] == 2) begin
                    if (bus.ack) begin
                        md[c] = 1; el[c] = 0;
                    end else if (snz) begin
                        md[c] = 3; el[c] = 0;
                    end else if (bus.sec_tick) begin
                        el[c]++;
                        if (el[c] == RING_SECS) begin md[c] = 1; el[c] = 0; to = 1'b1; end
                    end
                end else begin
                    if (bus.ack) begin
                        md[c] = 1; el[c] = 0;
                    end else if (bus.sec_tick) begin
                        el[c]++;
                        if (el[c] == SNOOZE_SECS) begin md[c] = 2; el[c] = 0; end
                    end
                end
                hh[c] = hit;
            end
            rr[c] = (md[c] == 2);
        end
        mode     <= md;
        elapsed  <= el;
        was_hit  <= hh;
        exp_ring <= rr;
        exp_to   <= reset ? 1'b0 : to;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Single compare process: every falling edge, DUT outputs against the model.
    always @(negedge clock) begin
        if (cmp_on) begin
            logic [AW-1:0] exp_act;
            exp_act = '0;
            for (int c = NUM_CH - 1; c >= 0; c--) if (exp_ring[c]) exp_act = AW'(c);
            chk("model_ring",    32'(bus.ring),      32'(exp_ring));
            chk("model_fin",     32'(bus.fin),       32'(exp_ring != 0));
            chk("model_active",  32'(bus.active_ch), 32'(exp_act));
            chk("model_timeout", 32'(bus.timeout),   32'(exp_to));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        bus.count_h = h; bus.count_m = m; bus.count_s = s;
    endtask

    task automatic set_prog(input int ch, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        bus.prog_h[ch*FIELD_W +: FIELD_W] = h;
        bus.prog_m[ch*FIELD_W +: FIELD_W] = m;
        bus.prog_s[ch*FIELD_W +: FIELD_W] = s;
    endtask

    function automatic logic [7:0] pick(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        int r;
        r = $urandom_range(2, 0);
        return (r == 0) ? a : ((r == 1) ? b : c);
    endfunction

    initial begin
        bus.sec_tick = 1'b0; bus.ack = 1'b0; bus.ch_en = '0;
        bus.prog_h = '0; bus.prog_m = '0; bus.prog_s = '0;
`ifdef ALARM_SNOOZE_EN
        bus.snooze = 1'b0;
`endif
        set_time(8'h00, 8'h00, 8'h01);
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cmp_on = 1'b1;
        chk("reset_ring", 32'(bus.ring), 32'd0);
        chk("reset_timeout", 32'(bus.timeout), 32'd0);

        // Single channel rings one cycle after the count reaches its program.
        bus.ch_en = 4'b0100;
        set_prog(2, 8'h07, 8'h30, 8'h00);
        set_time(8'h07, 8'h29, 8'h59);
        cyc(3);
        set_time(8'h07, 8'h30, 8'h00);
        cyc(1);
        chk("ch2_ring", 32'(bus.ring), 32'h4);
        chk("ch2_fin", 32'(bus.fin), 32'd1);
        chk("ch2_active", 32'(bus.active_ch), 32'd2);
        bus.ack = 1'b1;
        cyc(1);
        bus.ack = 1'b0;
        chk("ack_clears", 32'(bus.ring), 32'd0);
        cyc(4);
        chk("no_rering_same_sec", 32'(bus.ring), 32'd0);

        // Auto-timeout after RING_SECS ticks, then rings again on the next match.
        set_time(8'h07, 8'h29, 8'h59);
        cyc(2);
        set_time(8'h07, 8'h30, 8'h00);
        cyc(1);
        chk("ring_before_ticks", 32'(bus.ring), 32'h4);
        for (int k = 1; k <= RING_SECS; k++) begin
            bus.sec_tick = 1'b1;
            cyc(1);
            bus.sec_tick = 1'b0;
            if (k < RING_SECS) begin
                chk("still_ringing", 32'(bus.ring), 32'h4);
                cyc(1);
            end
        end
        chk("timeout_ring_low", 32'(bus.ring), 32'd0);
        chk("timeout_pulse", 32'(bus.timeout), 32'd1);
        cyc(1);
        chk("timeout_one_cycle", 32'(bus.timeout), 32'd0);
        set_time(8'h07, 8'h29, 8'h59);
        cyc(2);
        set_time(8'h07, 8'h30, 8'h00);
        cyc(1);
        chk("rering_next_match", 32'(bus.ring), 32'h4);
        bus.ack = 1'b1;
        cyc(1);
        bus.ack = 1'b0;

        // Two channels at the same time; lowest index reported; ack clears both.
        bus.ch_en = 4'b1001;
        set_prog(0, 8'h12, 8'h00, 8'h00);
        set_prog(3, 8'h12, 8'h00, 8'h00);
        set_time(8'h11, 8'h59, 8'h59);
        cyc(3);
        set_time(8'h12, 8'h00, 8'h00);
        cyc(1);
        chk("dual_ring", 32'(bus.ring), 32'h9);
        chk("dual_active", 32'(bus.active_ch), 32'd0);
        bus.ack = 1'b1;
        cyc(1);
        bus.ack = 1'b0;
        chk("dual_ack", 32'(bus.ring), 32'd0);

        // Zero program never matches; enabling while already matching does not ring.
        bus.ch_en = 4'b0010;
        set_prog(1, 8'h00, 8'h00, 8'h00);
        set_time(8'h00, 8'h00, 8'h00);
        cyc(4);
        chk("zero_prog_silent", 32'(bus.ring), 32'd0);
        bus.ch_en = 4'b0000;
        set_prog(1, 8'h08, 8'h00, 8'h00);
        set_time(8'h08, 8'h00, 8'h00);
        cyc(2);
        bus.ch_en = 4'b0010;
        cyc(4);
        chk("enable_while_match", 32'(bus.ring), 32'd0);

        // Reset while ringing clears everything.
        set_time(8'h07, 8'h59, 8'h59);
        cyc(2);
        set_time(8'h08, 8'h00, 8'h00);
        cyc(1);
        chk("ch1_ring", 32'(bus.ring), 32'h2);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("reset_mid_ring", 32'(bus.ring), 32'd0);
        chk("reset_mid_fin", 32'(bus.fin), 32'd0);
        chk("reset_mid_active", 32'(bus.active_ch), 32'd0);

`ifdef ALARM_SNOOZE_EN
        // Snooze silences for SNOOZE_SECS ticks; ack together with snooze arms.
        set_time(8'h07, 8'h59, 8'h59);
        cyc(3);
        set_time(8'h08, 8'h00, 8'h00);
        cyc(1);
        chk("snz_ring", 32'(bus.ring), 32'h2);
        bus.snooze = 1'b1;
        cyc(1);
        bus.snooze = 1'b0;
        chk("snz_quiet", 32'(bus.ring), 32'd0);
        for (int k = 1; k <= SNOOZE_SECS; k++) begin
            bus.sec_tick = 1'b1;
            cyc(1);
            bus.sec_tick = 1'b0;
            if (k < SNOOZE_SECS) begin
                chk("snz_still_quiet", 32'(bus.ring), 32'd0);
                cyc(1);
            end
        end
        chk("snz_rering", 32'(bus.ring), 32'h2);
        bus.ack = 1'b1; bus.snooze = 1'b1;
        cyc(1);
        bus.ack = 1'b0; bus.snooze = 1'b0;
        chk("ack_beats_snooze", 32'(bus.ring), 32'd0);
`endif

        // Randomized traffic over a small time alphabet so matches are frequent.
        for (int c = 0; c < NUM_CH; c++)
            set_prog(c, pick(8'h07, 8'h12, 8'h00), pick(8'h30, 8'h00, 8'h30), pick(8'h00, 8'h01, 8'h00));
        bus.ch_en = 4'b1111;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(3, 0) == 0)
                set_time(pick(8'h07, 8'h12, 8'h00), pick(8'h30, 8'h00, 8'h30), pick(8'h00, 8'h01, 8'h00));
            if ($urandom_range(60, 0) == 0)
                set_prog($urandom_range(NUM_CH - 1, 0), pick(8'h07, 8'h12, 8'h00),
                         pick(8'h30, 8'h00, 8'h30), pick(8'h00, 8'h01, 8'h00));
            if ($urandom_range(40, 0) == 0)
                bus.ch_en = 4'($urandom_range(15, 0)) | 4'b0101;
            bus.sec_tick = ($urandom_range(2, 0) == 0);
            bus.ack      = ($urandom_range(25, 0) == 0);
`ifdef ALARM_SNOOZE_EN
            bus.snooze   = ($urandom_range(20, 0) == 0);
`endif
            reset        = ($urandom_range(500, 0) == 0);
            cyc(1);
        end
        reset = 1'b0;
        bus.sec_tick = 1'b0; bus.ack = 1'b0;
        cyc(2);
        cmp_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
